// File: rtl/iter_seq_controller.sv
// Control sequencer for an iterative non-restoring shift/add-subtract datapath.
// Runs LOAD, ITERS shift steps, an optional correction step, then holds the result under valid/ack.
module iter_seq_controller #(
    parameter int ITERS   = 8,
    parameter int CNT_W   = 4,
    parameter bit CORRECT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             ack,
    input  logic             sign,
    output logic             load,
    output logic             add,
    output logic             shift,
    output logic             inbit,
    output logic [1:0]       sel,
    output logic             valid,
    output logic             busy,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [2:0] {IDLE, LOAD, ITER, CORR, DONE} state_t;

    localparam logic [CNT_W-1:0] ITERS_C = CNT_W'(ITERS);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    state_t           state_reg;
    logic [CNT_W-1:0] count_reg;
    logic             first_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= '0;
            first_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) state_reg <= LOAD;
                end
                LOAD: begin
                    if (abort) begin
                        state_reg <= IDLE;
                        count_reg <= '0;
                    end else begin
                        state_reg <= ITER;
                        count_reg <= ITERS_C;
                        first_reg <= 1'b1;
                    end
                end
                ITER: begin
                    first_reg <= 1'b0;
                    if (abort) begin
                        state_reg <= IDLE;
                        count_reg <= '0;
                    end else begin
                        count_reg <= count_reg - ONE_C;
                        if (count_reg == ONE_C) state_reg <= CORRECT ? CORR : DONE;
                    end
                end
                CORR: begin
                    state_reg <= abort ? IDLE : DONE;
                    count_reg <= '0;
                end
                DONE: begin
                    count_reg <= '0;
                    if (ack) state_reg <= start ? LOAD : IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    count_reg <= '0;
                    first_reg <= 1'b0;
                end
            endcase
        end
    end

    // The first iteration has no valid remainder sign yet, so it always subtracts.
    logic sign_eff;
    assign sign_eff = sign & ~first_reg;

    always_comb begin
        load  = 1'b0;
        add   = 1'b0;
        shift = 1'b0;
        inbit = 1'b0;
        sel   = 2'b10;
        valid = 1'b0;
        busy  = 1'b0;
        case (state_reg)
            LOAD: begin
                load = 1'b1;
                sel  = 2'b11;
                busy = 1'b1;
            end
            ITER: begin
                shift = 1'b1;
                sel   = 2'b00;
                busy  = 1'b1;
                add   = sign_eff;
                inbit = ~sign_eff;
            end
            CORR: begin
                sel  = 2'b01;
                busy = 1'b1;
                add  = sign;
            end
            DONE: valid = 1'b1;
            default: ;
        endcase
    end

    assign count = count_reg;

endmodule

// File: tb/tb_iter_seq_controller.sv
// Directed bench: dut_a is ITERS=8 with correction, dut_b is ITERS=4 without.
module tb_iter_seq_controller;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic a_start, a_abort, a_ack, a_sign;
    logic a_load, a_add, a_shift, a_inbit, a_valid, a_busy;
    logic [1:0] a_sel;
    logic [3:0] a_count;

    logic b_start, b_abort, b_ack, b_sign;
    logic b_load, b_add, b_shift, b_inbit, b_valid, b_busy;
    logic [1:0] b_sel;
    logic [2:0] b_count;

    int pass_cnt = 0;
    int total_cnt = 0;

    iter_seq_controller #(.ITERS(8), .CNT_W(4), .CORRECT(1'b1)) dut_a (
        .clk(clk), .reset(reset), .start(a_start), .abort(a_abort), .ack(a_ack), .sign(a_sign),
        .load(a_load), .add(a_add), .shift(a_shift), .inbit(a_inbit), .sel(a_sel),
        .valid(a_valid), .busy(a_busy), .count(a_count)
    );

    iter_seq_controller #(.ITERS(4), .CNT_W(3), .CORRECT(1'b0)) dut_b (
        .clk(clk), .reset(reset), .start(b_start), .abort(b_abort), .ack(b_ack), .sign(b_sign),
        .load(b_load), .add(b_add), .shift(b_shift), .inbit(b_inbit), .sel(b_sel),
        .valid(b_valid), .busy(b_busy), .count(b_count)
    );

    // Packed view {load, add, shift, inbit, sel, valid, busy}
    logic [7:0] a_vec, b_vec;
    assign a_vec = {a_load, a_add, a_shift, a_inbit, a_sel, a_valid, a_busy};
    assign b_vec = {b_load, b_add, b_shift, b_inbit, b_sel, b_valid, b_busy};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #3;
        total_cnt++;
        if (a_vec !== 8'b0000_1000 || a_count !== 4'd0)
            $display("FAIL reset_a: got vec=%b count=%0d want vec=00001000 count=0", a_vec, a_count);
        else pass_cnt++;
        total_cnt++;
        if (b_vec !== 8'b0000_1000 || b_count !== 3'd0)
            $display("FAIL reset_b: got vec=%b count=%0d want vec=00001000 count=0", b_vec, b_count);
        else pass_cnt++;
        @(posedge clk);
        #1;
        reset = 1'b1;
        step;
    endtask

    task automatic test_basic;
        a_start = 1'b1;
        step;
        a_start = 1'b0;
        total_cnt++;
        if (a_vec !== 8'b1000_1101)
            $display("FAIL basic_load: got vec=%b want 10001101", a_vec);
        else pass_cnt++;
        for (int c = 2; c <= 9; c++) begin
            step;
            total_cnt++;
            if (a_vec !== 8'b0011_0001 || a_count !== 4'(10 - c))
                $display("FAIL basic_iter c%0d: got vec=%b count=%0d want vec=00110001 count=%0d",
                         c, a_vec, a_count, 10 - c);
            else pass_cnt++;
        end
        step;
        total_cnt++;
        if (a_vec !== 8'b0000_0101)
            $display("FAIL basic_corr: got vec=%b want 00000101", a_vec);
        else pass_cnt++;
        step;
        total_cnt++;
        if (a_vec !== 8'b0000_1010 || a_count !== 4'd0)
            $display("FAIL basic_done: got vec=%b count=%0d want vec=00001010 count=0", a_vec, a_count);
        else pass_cnt++;
        a_ack = 1'b1;
        step;
        a_ack = 1'b0;
        total_cnt++;
        if (a_vec !== 8'b0000_1000)
            $display("FAIL basic_idle: got vec=%b want 00001000", a_vec);
        else pass_cnt++;
    endtask

    task automatic test_sign;
        a_start = 1'b1;
        step;
        a_start = 1'b0;
        for (int c = 2; c <= 10; c++) begin
            step;
            if (c == 4) begin
                a_sign = 1'b1;
                #1;
                total_cnt++;
                if (a_add !== 1'b1 || a_inbit !== 1'b0 || a_shift !== 1'b1)
                    $display("FAIL sign_iter4: got add=%b inbit=%b shift=%b want 1 0 1", a_add, a_inbit, a_shift);
                else pass_cnt++;
                a_sign = 1'b0;
            end
            if (c == 10) begin
                a_sign = 1'b1;
                #1;
                total_cnt++;
                if (a_add !== 1'b1 || a_sel !== 2'b01 || a_shift !== 1'b0 || a_inbit !== 1'b0)
                    $display("FAIL sign_corr: got add=%b sel=%b shift=%b inbit=%b want 1 01 0 0",
                             a_add, a_sel, a_shift, a_inbit);
                else pass_cnt++;
                a_sign = 1'b0;
            end
        end
        step;
        total_cnt++;
        if (a_valid !== 1'b1)
            $display("FAIL sign_done: got valid=%b want 1", a_valid);
        else pass_cnt++;
        a_ack = 1'b1;
        step;
        a_ack = 1'b0;
    endtask

    task automatic test_hold;
        b_start = 1'b1;
        step;
        b_start = 1'b0;
        for (int c = 2; c <= 5; c++) step;
        total_cnt++;
        if (b_valid !== 1'b0 || b_shift !== 1'b1 || b_count !== 3'd1)
            $display("FAIL hold_last_iter: got valid=%b shift=%b count=%0d want 0 1 1", b_valid, b_shift, b_count);
        else pass_cnt++;
        step;
        total_cnt++;
        if (b_vec !== 8'b0000_1010 || b_count !== 3'd0)
            $display("FAIL hold_valid6: got vec=%b count=%0d want vec=00001010 count=0", b_vec, b_count);
        else pass_cnt++;
        b_start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            b_abort = (k == 2);
            step;
            total_cnt++;
            if (b_vec !== 8'b0000_1010)
                $display("FAIL hold_k%0d: got vec=%b want 00001010", k, b_vec);
            else pass_cnt++;
        end
        b_abort = 1'b0;
        b_start = 1'b0;
        b_ack = 1'b1;
        step;
        b_ack = 1'b0;
        total_cnt++;
        if (b_vec !== 8'b0000_1000)
            $display("FAIL hold_idle: got vec=%b want 00001000", b_vec);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        b_start = 1'b1;
        step;
        b_start = 1'b0;
        for (int c = 2; c <= 6; c++) step;
        b_ack = 1'b1;
        b_start = 1'b1;
        step;
        b_ack = 1'b0;
        b_start = 1'b0;
        total_cnt++;
        if (b_vec !== 8'b1000_1101)
            $display("FAIL b2b_load: got vec=%b want 10001101", b_vec);
        else pass_cnt++;
        for (int c = 2; c <= 6; c++) step;
        total_cnt++;
        if (b_valid !== 1'b1 || b_busy !== 1'b0)
            $display("FAIL b2b_done: got valid=%b busy=%b want 1 0", b_valid, b_busy);
        else pass_cnt++;
        b_ack = 1'b1;
        step;
        b_ack = 1'b0;
    endtask

    task automatic test_abort;
        logic valid_seen;
        a_start = 1'b1;
        step;
        a_start = 1'b0;
        step;
        a_sign = 1'b1;
        #1;
        total_cnt++;
        if (a_add !== 1'b0 || a_inbit !== 1'b1 || a_count !== 4'd8)
            $display("FAIL abort_first_iter: got add=%b inbit=%b count=%0d want 0 1 8", a_add, a_inbit, a_count);
        else pass_cnt++;
        a_sign = 1'b0;
        step;
        step;
        step;
        total_cnt++;
        if (a_count !== 4'd5 || a_busy !== 1'b1)
            $display("FAIL abort_c5: got count=%0d busy=%b want 5 1", a_count, a_busy);
        else pass_cnt++;
        a_abort = 1'b1;
        step;
        a_abort = 1'b0;
        total_cnt++;
        if (a_vec !== 8'b0000_1000 || a_count !== 4'd0)
            $display("FAIL abort_idle: got vec=%b count=%0d want vec=00001000 count=0", a_vec, a_count);
        else pass_cnt++;
        valid_seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step;
            valid_seen = valid_seen | a_valid | a_busy;
        end
        total_cnt++;
        if (valid_seen !== 1'b0)
            $display("FAIL abort_quiet: got valid_or_busy=%b want 0", valid_seen);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        a_start = 1'b1;
        step;
        a_start = 1'b0;
        step;
        step;
        step;
        #2;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (a_vec !== 8'b0000_1000 || a_count !== 4'd0)
            $display("FAIL rstmid_async: got vec=%b count=%0d want vec=00001000 count=0", a_vec, a_count);
        else pass_cnt++;
        @(negedge clk);
        reset = 1'b1;
        a_start = 1'b1;
        step;
        a_start = 1'b0;
        total_cnt++;
        if (a_load !== 1'b1)
            $display("FAIL rstmid_load: got load=%b want 1", a_load);
        else pass_cnt++;
        for (int c = 2; c <= 10; c++) begin
            step;
            total_cnt++;
            if (a_busy !== 1'b1 || a_valid !== 1'b0)
                $display("FAIL rstmid_busy c%0d: got busy=%b valid=%b want 1 0", c, a_busy, a_valid);
            else pass_cnt++;
        end
        step;
        total_cnt++;
        if (a_valid !== 1'b1 || a_busy !== 1'b0)
            $display("FAIL rstmid_done: got valid=%b busy=%b want 1 0", a_valid, a_busy);
        else pass_cnt++;
        a_ack = 1'b1;
        step;
        a_ack = 1'b0;
    endtask

    initial begin
        a_start = 1'b0; a_abort = 1'b0; a_ack = 1'b0; a_sign = 1'b0;
        b_start = 1'b0; b_abort = 1'b0; b_ack = 1'b0; b_sign = 1'b0;
        test_reset;
        test_basic;
        test_sign;
        test_hold;
        test_back_to_back;
        test_abort;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
